// File: rtl/mpc_types.sv
// Shared types and default sizes for the xbar bank pop scheduler.
// Latency: n/a (types only).
// Backpressure: n/a.
package mpc_types;

  localparam int XBAR_NUM_CH   = 3;
  localparam int XBAR_NUM_BANK = 4;
  localparam int XBAR_PTR_W    = 3;

  // Channel index carried on the grant bus is fixed at 2 bits (up to 4 channels).
  typedef logic [1:0]            xbar_ch_idx_t;
  typedef logic [XBAR_PTR_W-1:0] xbar_ptr_t;

endpackage

// File: rtl/xbar_bank_rr_arb.sv
// Per-bank round-robin arbiter: picks one eligible channel and holds the grant until the bank accepts it.
// Latency: eligibility at cycle N -> registered grant at N+1; next grant follows a handshake with no bubble.
// Backpressure: while gnt_vld_o & ~bank_ready_i the grant (valid/ch/ptr) is frozen and never withdrawn.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   elig_i            per-channel eligibility for this bank (already excludes done and the current handshake)
//   ch_r_ptr_i        all channel read pointers, flattened; the granted one is sampled at grant time
//   bank_ready_i      bank accepts the presented grant
//   gnt_vld_o/ch_o/ptr_o  registered grant
//   timeout_o         sticky stall timeout (only with XBAR_POP_SCHED_TIMEOUT_EN, else tied 0)
module xbar_bank_rr_arb
  import mpc_types::*;
#(
  parameter int NUM_CH = XBAR_NUM_CH,
  parameter int PTR_W  = XBAR_PTR_W,
  parameter int TO_CYC = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       elig_i,
  input  logic [NUM_CH*PTR_W-1:0] ch_r_ptr_i,
  input  logic                    bank_ready_i,
  output logic                    gnt_vld_o,
  output logic [1:0]              gnt_ch_o,
  output logic [PTR_W-1:0]        gnt_ptr_o,
  output logic                    timeout_o
);

  if (TO_CYC < 1) begin : g_to_chk
    $error("xbar_bank_rr_arb: TO_CYC must be at least 1");
  end

  logic             gnt_vld_q, gnt_vld_d;
  xbar_ch_idx_t     gnt_ch_q, gnt_ch_d;
  logic [PTR_W-1:0] gnt_ptr_q, gnt_ptr_d;
  xbar_ch_idx_t     last_q, last_d;
  logic             hs, hold;
  logic             pick_vld;
  xbar_ch_idx_t     pick_ch;

  assign hs   = gnt_vld_q & bank_ready_i;
  assign hold = gnt_vld_q & ~bank_ready_i;
  // The pick for the next cycle already starts after the channel being accepted now.
  assign last_d = hs ? gnt_ch_q : last_q;

  always_comb begin
    pick_vld = 1'b0;
    pick_ch  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!pick_vld && elig_i[(int'(last_d) + k) % NUM_CH]) begin
        pick_vld = 1'b1;
        pick_ch  = xbar_ch_idx_t'((int'(last_d) + k) % NUM_CH);
      end
    end
  end

  always_comb begin
    gnt_vld_d = gnt_vld_q;
    gnt_ch_d  = gnt_ch_q;
    gnt_ptr_d = gnt_ptr_q;
    if (!hold) begin
      gnt_vld_d = pick_vld;
      gnt_ch_d  = pick_ch;
      gnt_ptr_d = pick_vld ? ch_r_ptr_i[int'(pick_ch)*PTR_W +: PTR_W] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_vld_q <= 1'b0;
      gnt_ch_q  <= '0;
      gnt_ptr_q <= '0;
      last_q    <= xbar_ch_idx_t'(NUM_CH - 1);
    end else begin
      gnt_vld_q <= gnt_vld_d;
      gnt_ch_q  <= gnt_ch_d;
      gnt_ptr_q <= gnt_ptr_d;
      last_q    <= last_d;
    end
  end

  assign gnt_vld_o = gnt_vld_q;
  assign gnt_ch_o  = gnt_ch_q;
  assign gnt_ptr_o = gnt_ptr_q;

`ifdef XBAR_POP_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TO_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  always_comb begin
    cnt_d = '0;
    if (hold) begin
      cnt_d = (cnt_q == CNT_W'(TO_CYC)) ? cnt_q : cnt_q + CNT_W'(1);
    end
    tmo_d = tmo_q | (cnt_q == CNT_W'(TO_CYC));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout_o = tmo_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: rtl/xbar_bank_pop_sched.sv
// Per-bank pop scheduler: NUM_CH channels each pop their current entry once from every one of NUM_BANK banks.
// Latency: request at N -> grant at N+1 -> popped flag at N+1 after the handshake cycle.
// Backpressure: bank_ready low freezes that bank's grant; other banks arbitrate independently.
//
// Ports: clk/rst (async active-high); ch_pop_req[c*NUM_BANK+b]; ch_r_ptr[c]; bank_ready[b];
//   bank_gnt_valid/ch/ptr per bank; ch_bank_last_entry_already_pop (popped flags, same layout as ch_pop_req);
//   bank_timeout per bank.
// Optional feature: define XBAR_POP_SCHED_TIMEOUT_EN to enable the per-bank stall timeout.
module xbar_bank_pop_sched
  import mpc_types::*;
#(
  parameter int NUM_CH   = XBAR_NUM_CH,
  parameter int NUM_BANK = XBAR_NUM_BANK,
  parameter int PTR_W    = XBAR_PTR_W,
  parameter int TO_CYC   = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*NUM_BANK-1:0] ch_pop_req,
  input  logic [NUM_CH*PTR_W-1:0]    ch_r_ptr,
  input  logic [NUM_BANK-1:0]        bank_ready,
  output logic [NUM_BANK-1:0]        bank_gnt_valid,
  output logic [NUM_BANK*2-1:0]      bank_gnt_ch,
  output logic [NUM_BANK*PTR_W-1:0]  bank_gnt_ptr,
  output logic [NUM_CH*NUM_BANK-1:0] ch_bank_last_entry_already_pop,
  output logic [NUM_BANK-1:0]        bank_timeout
);

  if (NUM_CH > 4) begin : g_nch_chk
    $error("xbar_bank_pop_sched: NUM_CH must be <= 4 (2-bit grant channel)");
  end

  logic [NUM_CH*NUM_BANK-1:0] done_q, done_d;
  logic [NUM_CH*PTR_W-1:0]    prev_ptr_q;
  logic [NUM_BANK-1:0]        hs;
  logic [NUM_CH-1:0]          elig [NUM_BANK];

  assign hs = bank_gnt_valid & bank_ready;

  // A channel being accepted this cycle is masked so the bank can move straight on to the next one.
  always_comb begin
    for (int b = 0; b < NUM_BANK; b++) begin
      elig[b] = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        elig[b][c] = ch_pop_req[c*NUM_BANK+b] & ~done_q[c*NUM_BANK+b]
                     & ~(hs[b] && (int'(bank_gnt_ch[b*2 +: 2]) == c));
      end
    end
  end

  // Pointer change clears the whole row and wins over a same-cycle set.
  always_comb begin
    done_d = done_q;
    for (int b = 0; b < NUM_BANK; b++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (hs[b] && (int'(bank_gnt_ch[b*2 +: 2]) == c)) begin
          done_d[c*NUM_BANK+b] = 1'b1;
        end
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_r_ptr[c*PTR_W +: PTR_W] != prev_ptr_q[c*PTR_W +: PTR_W]) begin
        done_d[c*NUM_BANK +: NUM_BANK] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q     <= '0;
      prev_ptr_q <= '0;
    end else begin
      done_q     <= done_d;
      prev_ptr_q <= ch_r_ptr;
    end
  end

  assign ch_bank_last_entry_already_pop = done_q;

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    xbar_bank_rr_arb #(
      .NUM_CH (NUM_CH),
      .PTR_W  (PTR_W),
      .TO_CYC (TO_CYC)
    ) u_arb (
      .clk          (clk),
      .rst          (rst),
      .elig_i       (elig[b]),
      .ch_r_ptr_i   (ch_r_ptr),
      .bank_ready_i (bank_ready[b]),
      .gnt_vld_o    (bank_gnt_valid[b]),
      .gnt_ch_o     (bank_gnt_ch[b*2 +: 2]),
      .gnt_ptr_o    (bank_gnt_ptr[b*PTR_W +: PTR_W]),
      .timeout_o    (bank_timeout[b])
    );
  end

endmodule

// File: tb/tb_xbar_bank_pop_sched.sv
module tb_xbar_bank_pop_sched;
  localparam int NC = 3;
  localparam int NB = 4;
  localparam int PW = 3;
  localparam int TO = 64;
`ifdef XBAR_POP_SCHED_TIMEOUT_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NC*NB-1:0]  ch_pop_req;
  logic [NC*PW-1:0]  ch_r_ptr;
  logic [NB-1:0]     bank_ready;
  logic [NB-1:0]     bank_gnt_valid;
  logic [NB*2-1:0]   bank_gnt_ch;
  logic [NB*PW-1:0]  bank_gnt_ptr;
  logic [NC*NB-1:0]  done_o;
  logic [NB-1:0]     bank_timeout;

  always #5 clk = ~clk;

  xbar_bank_pop_sched #(.NUM_CH(NC), .NUM_BANK(NB), .PTR_W(PW), .TO_CYC(TO)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .ch_pop_req                     (ch_pop_req),
    .ch_r_ptr                       (ch_r_ptr),
    .bank_ready                     (bank_ready),
    .bank_gnt_valid                 (bank_gnt_valid),
    .bank_gnt_ch                    (bank_gnt_ch),
    .bank_gnt_ptr                   (bank_gnt_ptr),
    .ch_bank_last_entry_already_pop (done_o),
    .bank_timeout                   (bank_timeout)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per-bank pending grant, popped flags, rr last-grant, previous pointers.
  bit m_vld [NB];
  int m_ch  [NB];
  int m_ptr [NB];
  int m_last[NB];
  int m_cnt [NB];
  bit m_tmo [NB];
  bit m_done[NC][NB];
  int m_prev[NC];

  function automatic void model_reset();
    for (int b = 0; b < NB; b++) begin
      m_vld[b] = 0; m_ch[b] = 0; m_ptr[b] = 0; m_last[b] = NC - 1; m_cnt[b] = 0; m_tmo[b] = 0;
    end
    for (int c = 0; c < NC; c++) begin
      m_prev[c] = 0;
      for (int b = 0; b < NB; b++) m_done[c][b] = 0;
    end
  endfunction

  function automatic void model_step();
    bit hs[NB];
    bit nd[NC][NB];
    int p[NC];
    int old_ch;
    int c;
    for (int i = 0; i < NC; i++) p[i] = int'(ch_r_ptr[i*PW +: PW]);
    for (int b = 0; b < NB; b++) hs[b] = m_vld[b] && bank_ready[b];
    nd = m_done;
    for (int b = 0; b < NB; b++) if (hs[b]) nd[m_ch[b]][b] = 1;
    for (int i = 0; i < NC; i++)
      if (p[i] != m_prev[i]) for (int b = 0; b < NB; b++) nd[i][b] = 0;
    for (int b = 0; b < NB; b++) begin
      if (TE) begin
        if (m_cnt[b] == TO) m_tmo[b] = 1;
        if (m_vld[b] && !bank_ready[b]) m_cnt[b] = (m_cnt[b] < TO) ? m_cnt[b] + 1 : TO;
        else m_cnt[b] = 0;
      end
      old_ch = m_ch[b];
      if (hs[b]) m_last[b] = old_ch;
      if (!(m_vld[b] && !bank_ready[b])) begin
        m_vld[b] = 0;
        for (int k = 1; k <= NC; k++) begin
          c = (m_last[b] + k) % NC;
          if (!m_vld[b] && ch_pop_req[c*NB+b] && !m_done[c][b] && !(hs[b] && old_ch == c)) begin
            m_vld[b] = 1; m_ch[b] = c; m_ptr[b] = p[c];
          end
        end
      end
    end
    m_done = nd;
    m_prev = p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ptr(input int c, input int v);
    ch_r_ptr[c*PW +: PW] = PW'(v);
  endtask

  function automatic int gch(input int b);
    return int'(bank_gnt_ch[b*2 +: 2]);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    ch_pop_req = '0; ch_r_ptr = '0; bank_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick();
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ch_pop_req = '0; ch_r_ptr = '0; bank_ready = '0;
    #2 rst = 1'b1;
    #2;
    n_cmp++; if (bank_gnt_valid !== '0) begin n_bad++; $display("FAIL reset_gnt_valid got %0h want 0", bank_gnt_valid); end
    n_cmp++; if (bank_gnt_ch !== '0) begin n_bad++; $display("FAIL reset_gnt_ch got %0h want 0", bank_gnt_ch); end
    n_cmp++; if (bank_gnt_ptr !== '0) begin n_bad++; $display("FAIL reset_gnt_ptr got %0h want 0", bank_gnt_ptr); end
    n_cmp++; if (done_o !== '0) begin n_bad++; $display("FAIL reset_done got %0h want 0", done_o); end
    n_cmp++; if (bank_timeout !== '0) begin n_bad++; $display("FAIL reset_timeout got %0h want 0", bank_timeout); end
    do_reset();
  endtask

  task automatic test_single();
    ch_pop_req = '0; ch_pop_req[0] = 1'b1; bank_ready = '1;
    tick();
    n_cmp++; if (bank_gnt_valid !== 4'b0001) begin n_bad++; $display("FAIL single_gnt got %0h want 1", bank_gnt_valid); end
    n_cmp++; if (gch(0) != 0) begin n_bad++; $display("FAIL single_ch got %0d want 0", gch(0)); end
    n_cmp++; if (done_o !== '0) begin n_bad++; $display("FAIL single_done_early got %0h want 0", done_o); end
    tick();
    n_cmp++; if (done_o !== 12'h001) begin n_bad++; $display("FAIL single_done got %0h want 1", done_o); end
    n_cmp++; if (bank_gnt_valid !== '0) begin n_bad++; $display("FAIL single_drop got %0h want 0", bank_gnt_valid); end
    tick();
    n_cmp++; if (bank_gnt_valid !== '0) begin n_bad++; $display("FAIL single_norepeat got %0h want 0", bank_gnt_valid); end
  endtask

  task automatic test_collision();
    ch_pop_req = '0;
    for (int c = 0; c < NC; c++) set_ptr(c, 1);
    tick(); tick();
    for (int c = 0; c < NC; c++) ch_pop_req[c*NB+2] = 1'b1;
    for (int k = 0; k < NC; k++) begin
      tick();
      n_cmp++; if (!bank_gnt_valid[2] || gch(2) != k) begin
        n_bad++; $display("FAIL collision_order[%0d] got vld=%0b ch=%0d want vld=1 ch=%0d", k, bank_gnt_valid[2], gch(2), k);
      end
    end
    tick();
    n_cmp++; if (bank_gnt_valid[2] !== 1'b0) begin n_bad++; $display("FAIL collision_end got 1 want 0"); end
    tick();
    n_cmp++; if (bank_gnt_valid[2] !== 1'b0) begin n_bad++; $display("FAIL collision_norepeat got 1 want 0"); end
    n_cmp++; if ({done_o[10], done_o[6], done_o[2]} !== 3'b111) begin
      n_bad++; $display("FAIL collision_done got %0h", done_o);
    end
  endtask

  task automatic test_hold();
    ch_pop_req = '0; ch_pop_req[1*NB+3] = 1'b1; bank_ready = 4'b0111;
    set_ptr(1, 5);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 2) ch_pop_req = '0;
      n_cmp++; if (!bank_gnt_valid[3] || gch(3) != 1 || bank_gnt_ptr[3*PW +: PW] !== 3'd5) begin
        n_bad++; $display("FAIL hold_stable[%0d] got vld=%0b ch=%0d ptr=%0d want 1/1/5", i, bank_gnt_valid[3], gch(3), bank_gnt_ptr[3*PW +: PW]);
      end
    end
    bank_ready = '1;
    tick();
    n_cmp++; if (done_o[1*NB+3] !== 1'b1 || bank_gnt_valid[3] !== 1'b0) begin
      n_bad++; $display("FAIL hold_handshake got done=%0b vld=%0b want 1/0", done_o[1*NB+3], bank_gnt_valid[3]);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    ch_pop_req = '0; ch_pop_req[NB-1:0] = '1; bank_ready = '1;
    set_ptr(0, 7);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      ok = (done_o[NB-1:0] == 4'hF);
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_alldone got %0h want f", done_o[NB-1:0]); end
    set_ptr(0, 0);
    tick();
    n_cmp++; if (done_o[NB-1:0] !== 4'h0) begin n_bad++; $display("FAIL wrap_clear got %0h want 0", done_o[NB-1:0]); end
    n_cmp++; if (bank_gnt_valid !== 4'h0) begin n_bad++; $display("FAIL wrap_nogrant got %0h want 0", bank_gnt_valid); end
    tick();
    n_cmp++; if (bank_gnt_valid !== 4'hF || bank_gnt_ch !== 8'h00) begin
      n_bad++; $display("FAIL wrap_regrant got vld=%0h ch=%0h want f/00", bank_gnt_valid, bank_gnt_ch);
    end
  endtask

  task automatic test_fairness();
    int pops[$];
    int c;
    do_reset();
    ch_pop_req[0*NB+1] = 1'b1; ch_pop_req[1*NB+1] = 1'b1; bank_ready = '1;
    for (int i = 0; i < 30 && pops.size() < 8; i++) begin
      tick();
      if (bank_gnt_valid[1]) begin
        c = gch(1);
        pops.push_back(c);
        set_ptr(c, int'(ch_r_ptr[c*PW +: PW]) + 1);
      end
    end
    n_cmp++; if (pops.size() != 8) begin n_bad++; $display("FAIL fair_count got %0d want 8", pops.size()); end
    for (int k = 0; k < pops.size(); k++) begin
      n_cmp++; if (pops[k] != k % 2) begin n_bad++; $display("FAIL fair_seq[%0d] got %0d want %0d", k, pops[k], k % 2); end
    end
    rst = 1'b1;
    #1;
    n_cmp++; if (bank_gnt_valid !== '0 || done_o !== '0) begin
      n_bad++; $display("FAIL midreset got vld=%0h done=%0h want 0/0", bank_gnt_valid, done_o);
    end
    do_reset();
  endtask

  task automatic test_timeout();
    logic [NB-1:0] want;
    do_reset();
    ch_pop_req[2*NB+0] = 1'b1; bank_ready = 4'b1110;
    want = TE ? 4'b0001 : 4'b0000;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (i == 60) begin
        n_cmp++; if (bank_timeout !== '0) begin n_bad++; $display("FAIL timeout_early got %0h want 0", bank_timeout); end
      end
    end
    n_cmp++; if (bank_timeout !== want) begin n_bad++; $display("FAIL timeout_hit got %0h want %0h", bank_timeout, want); end
    n_cmp++; if (bank_gnt_valid[0] !== 1'b1 || gch(0) != 2) begin
      n_bad++; $display("FAIL timeout_grant got vld=%0b ch=%0d want 1/2", bank_gnt_valid[0], gch(0));
    end
    ch_pop_req = '0; bank_ready = '1;
    repeat (3) tick();
    n_cmp++; if (bank_timeout !== want) begin n_bad++; $display("FAIL timeout_sticky got %0h want %0h", bank_timeout, want); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bank_timeout !== '0) begin n_bad++; $display("FAIL timeout_rst got %0h want 0", bank_timeout); end
    do_reset();
  endtask

  task automatic test_random();
    logic [NB-1:0]    ev;
    logic [NC*NB-1:0] ed;
    logic [NB-1:0]    et;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      ch_pop_req = (NC*NB)'($urandom);
      for (int b = 0; b < NB; b++) bank_ready[b] = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NC; c++) if ($urandom_range(0, 7) == 0) set_ptr(c, $urandom_range(0, 7));
      model_step();
      tick();
      for (int b = 0; b < NB; b++) begin ev[b] = m_vld[b]; et[b] = m_tmo[b]; end
      for (int c = 0; c < NC; c++) for (int b = 0; b < NB; b++) ed[c*NB+b] = m_done[c][b];
      n_cmp++; if (bank_gnt_valid !== ev) begin n_bad++; $display("FAIL rnd_vld@%0d got %0h want %0h", n, bank_gnt_valid, ev); end
      n_cmp++; if (done_o !== ed) begin n_bad++; $display("FAIL rnd_done@%0d got %0h want %0h", n, done_o, ed); end
      n_cmp++; if (bank_timeout !== et) begin n_bad++; $display("FAIL rnd_tmo@%0d got %0h want %0h", n, bank_timeout, et); end
      for (int b = 0; b < NB; b++) begin
        if (m_vld[b]) begin
          n_cmp++; if (gch(b) != m_ch[b] || int'(bank_gnt_ptr[b*PW +: PW]) != m_ptr[b]) begin
            n_bad++; $display("FAIL rnd_gnt@%0d b%0d got ch=%0d ptr=%0d want ch=%0d ptr=%0d", n, b, gch(b), bank_gnt_ptr[b*PW +: PW], m_ch[b], m_ptr[b]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_collision();
    test_hold();
    test_wrap();
    test_fairness();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
